// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and helpers for the ROM download path.
//   state_e   : download FSM states (IDLE, LOAD, DRAIN, HOLD)
//   IOCTL_AW  : width of the ioctl byte offset coming from mist_io
//   DATA_W    : width of one download byte
//   bank_w()  : width of one page-table entry (bank number)
//   entry_w() : width of one packed FIFO entry {addr, data}
// The packed FIFO entry struct itself is declared inside rom_loader as
// struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}, because
// its address width follows that module's ADDR_W parameter.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int IOCTL_AW = 25;
  localparam int DATA_W   = 8;

  function automatic int bank_w(input int addr_w, input int page_w);
    return addr_w - page_w;
  endfunction

  function automatic int entry_w(input int addr_w);
    return addr_w + DATA_W;
  endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo: small synchronous FIFO buffering download writes.
//   clk, srst : clock and synchronous active-high reset
//   push, din : write strobe and entry (ignored while full)
//   pop       : remove head entry (ignored while empty)
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   last      : exactly one entry stored
//   head      : oldest entry, valid while !empty
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_loader_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign last    = (count_q == CW'(1));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is read combinationally so a byte can reach the memory port the
  // cycle after it was pushed.
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: ROM download path from mist_io ioctl to the SDRAM write mux.
// Maps each download page through a runtime page table, buffers writes in a
// FIFO with a we/ack handshake, and holds the core in reset during download
// plus RELEASE_CYCLES cycles after the last write is accepted.
//   clk_sys, reset           : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : download stream from mist_io
//   page_map, page_valid     : bank per page (BW bits each) and enable mask
//   mem_we/addr/din, mem_ack : write request toward memory controller
//   boot_reset, busy         : core reset request, FSM not idle
//   overflow, unmapped       : sticky dropped-byte flags
//   pages_loaded             : pages that received at least one byte
//   checksum                 : byte sum (only with ROM_LOADER_CHECKSUM_EN)
// Optional macro: ROM_LOADER_CHECKSUM_EN enables the 16-bit checksum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int PAGE_W         = 14,
  parameter int NUM_PAGES      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int RELEASE_CYCLES = 16,
  parameter int ROM_INDEX      = 0
) (
  input  logic                                    clk_sys,
  input  logic                                    reset,
  input  logic                                    ioctl_download,
  input  logic [7:0]                              ioctl_index,
  input  logic                                    ioctl_wr,
  input  logic [IOCTL_AW-1:0]                     ioctl_addr,
  input  logic [7:0]                              ioctl_dout,
  input  logic [NUM_PAGES*(ADDR_W-PAGE_W)-1:0]    page_map,
  input  logic [NUM_PAGES-1:0]                    page_valid,
  output logic                                    mem_we,
  output logic [ADDR_W-1:0]                       mem_addr,
  output logic [7:0]                              mem_din,
  input  logic                                    mem_ack,
  output logic                                    boot_reset,
  output logic                                    busy,
  output logic                                    overflow,
  output logic                                    unmapped,
  output logic [NUM_PAGES-1:0]                    pages_loaded,
  output logic [15:0]                             checksum
);

  localparam int BW   = bank_w(ADDR_W, PAGE_W);
  localparam int PNW  = IOCTL_AW - PAGE_W;
  localparam int IW   = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int CNTW = $clog2(RELEASE_CYCLES + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Page decode
  logic [BW-1:0]        bank_tbl [NUM_PAGES];
  logic [NUM_PAGES-1:0] page_hot;
  logic [PNW-1:0]       page;
  logic [IW-1:0]        page_idx;
  logic                 mapped;
  logic [ADDR_W-1:0]    mapped_addr;

  assign page     = ioctl_addr[IOCTL_AW-1:PAGE_W];
  assign page_idx = page[IW-1:0];

  // Full-width compare per entry, so out-of-range pages never alias onto
  // a low entry.
  for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
    assign bank_tbl[gi] = page_map[gi*BW +: BW];
    assign page_hot[gi] = (page == PNW'(gi));
  end

  assign mapped      = |(page_hot & page_valid);
  assign mapped_addr = {bank_tbl[page_idx], ioctl_addr[PAGE_W-1:0]};

  // FSM and flag state
  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 unmapped_q, unmapped_d;
  logic [NUM_PAGES-1:0] pages_q, pages_d;
  logic                 gap_q;

  logic   active;
  logic   wr_seen;
  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_last;
  entry_t push_entry;
  entry_t fifo_head;

  assign active     = ioctl_download & (ioctl_index == 8'(ROM_INDEX));
  assign wr_seen    = (state_q == LOAD) & active & ioctl_wr;
  // Full is the pre-pop value, so a push on a full FIFO is dropped even
  // when the head leaves in the same cycle.
  assign push       = wr_seen & mapped & ~fifo_full;
  assign push_entry = '{addr: mapped_addr, data: ioctl_dout};

  rom_loader_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .srst  (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last),
    .head  (fifo_head)
  );

  // gap_q forces one idle cycle after each accepted write so the
  // controller sees a fresh request edge per entry.
  assign mem_we   = ~fifo_empty & ~gap_q;
  assign pop      = mem_we & mem_ack;
  assign mem_addr = mem_we ? fifo_head.addr : '0;
  assign mem_din  = mem_we ? fifo_head.data : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    unmapped_d = unmapped_q;
    pages_d    = pages_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d    = LOAD;
          overflow_d = 1'b0;
          unmapped_d = 1'b0;
          pages_d    = '0;
        end
      end
      LOAD: begin
        if (wr_seen) begin
          if (!mapped)        unmapped_d = 1'b1;
          else if (fifo_full) overflow_d = 1'b1;
          else                pages_d    = pages_q | page_hot;
        end
        if (!active) state_d = DRAIN;
      end
      DRAIN: begin
        if (active) begin
          state_d = LOAD;
        end else if (fifo_empty || (pop && fifo_last)) begin
          // Leave on the cycle the last entry is accepted so the release
          // count starts right at that pop.
          state_d = HOLD;
          cnt_d   = CNTW'(RELEASE_CYCLES - 1);
        end
      end
      HOLD: begin
        if (active) begin
          state_d = LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      unmapped_q <= 1'b0;
      pages_q    <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      unmapped_q <= unmapped_d;
      pages_q    <= pages_d;
      gap_q      <= pop;
    end
  end

  assign boot_reset   = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign unmapped     = unmapped_q;
  assign pages_loaded = pages_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == IDLE) && active) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q + {8'h00, ioctl_dout};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
